// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise-operation interface: opcodes, unit FSM
// states and the one-bit operation used by the serial datapath.
package bitwise_pkg;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_XNOR = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // One result bit for opcode op; illegal opcodes yield 0.
    function automatic logic bit_op(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = a ~^ b;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_XNOR;
    endfunction

endpackage

// File: rtl/bitwise_serial_unit.sv
// Bit-serial bitwise execution unit: accepts an operand pair, computes one
// result bit per cycle LSB first, and returns the whole word on a handshake.
module bitwise_serial_unit
    import bitwise_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       out_op,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [WIDTH-1:0] xs_q;
    logic [WIDTH-1:0] ys_q;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       op_q;
    logic [2:0]       out_op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             err_q;

    logic             shift_bit;
    logic             last_shift;

    // Current LSB pair through the opcode; last_shift marks the WIDTH-th shift edge.
    always_comb begin
        shift_bit  = bit_op(op_q, xs_q[0], ys_q[0]);
        last_shift = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM, operand/result shift registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            xs_q        <= '0;
            ys_q        <= '0;
            result_q    <= '0;
            op_q        <= '0;
            out_op_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        xs_q       <= x;
                        ys_q       <= y;
                        op_q       <= op;
                        result_q   <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    // New bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
                    result_q <= (result_q >> 1) | (WIDTH'(shift_bit) << (WIDTH - 1));
                    xs_q     <= xs_q >> 1;
                    ys_q     <= ys_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_shift) begin
                        out_valid_q <= 1'b1;
                        out_op_q    <= op_q;
                        err_q       <= op_illegal(op_q);
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_op    = out_op_q;
    assign err       = err_q;

endmodule

// File: doc/bitwise_serial_unit.md
Name: bitwise_serial_unit

Overview:
Handshaked, bit-serial execution unit for the team's five bitwise operations: NOT, AND, OR, XOR and XNOR. It accepts an operand pair and an opcode on a valid/ready input port. It computes the result one bit per cycle, LSB first, through shift registers. It returns the full word on a valid/ready output port. This is the consumer side of our bitwise-operation interface: an upstream requester issues the operation, and this block executes it and hands back the result.

Parameters:
WIDTH, 4, operand/result width in bits (>=1).
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept a request.
op  input  3  opcode: 0 NOT(~x), 1 AND, 2 OR, 3 XOR, 4 XNOR(x ^~ y), 5-7 illegal.
x  input  WIDTH  operand x.
y  input  WIDTH  operand y (ignored for NOT).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  computed word.
out_op  output  3  opcode echoed with result.
err  output  1  illegal opcode flag, valid with out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: state=IDLE; in_ready=1; out_valid=0; result=0; out_op=0; err=0; counter=0; shift registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: latch x, y and op into shift/op registers, clear the result register and counter, go to SHIFT.
  - Operands are sampled only on the accept edge; later changes to x/y/op are ignored.
- SHIFT:
  - in_ready=0.
  - Each edge: compute r = f(op, xs[0], ys[0]) and shift it into result MSB (result >> 1 | r << (WIDTH-1)); shift xs and ys right by 1; counter+1.
  - After WIDTH shift edges (counter reaches WIDTH), go to DONE.
  - result is all-LSB-aligned after exactly WIDTH shifts.
- DONE:
  - out_valid=1; result, out_op and err are stable and held while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - in_ready rises the cycle after the output handshake; there is no same-cycle turnaround.
- Latency: out_valid is first seen high WIDTH+1 cycles after the cycle in which the request was accepted. Throughput is one request per WIDTH+2 cycles minimum.
- Illegal op (5-7): still runs WIDTH cycles; result=0, err=1.
- Legal op: err=0.
- out_ready held high before DONE has no effect. in_valid while busy is ignored; the request is not lost, because the requester holds it until in_ready.
- rst asserted in any state, including mid-SHIFT or DONE with out_valid high: the next edge returns to reset values. The in-flight request is discarded with no partial result.
- WIDTH=1: a single SHIFT cycle; everything else is unchanged.

Decomposition:
- Shared package bitwise_pkg:
  - opcode enum/constants: OP_NOT=3'd0, OP_AND=3'd1, OP_OR=3'd2, OP_XOR=3'd3, OP_XNOR=3'd4.
  - FSM state typedef.
  - function bit_op(op, a, b) returning 1 bit.
- Requester and bench reuse the package for the golden model.
- No sub-module. The one-bit operation is the package function, and the FSM, counter and shift path stay in one module.

Test Plan:
1. Reset, then x=4'b0101, y=4'b1100 with op=0..4 in sequence -> results in order: 1010, 0100, 1101, 1001, 0110. out_op echoes each opcode, err=0, and each out_valid appears 5 cycles after its accept cycle.
2. out_ready held low 7 cycles in DONE -> out_valid and result stay stable. x/y changed during SHIFT -> result unaffected (op=AND on 0101/1100 still gives 0100).
3. op=3'd6, x=4'b1111, y=4'b1111 -> result=0000, err=1, and the next legal request has err=0.
4. rst pulsed 1 cycle mid-SHIFT (after 2 shifts) -> next cycle shows in_ready=1, out_valid=0, result=0. A subsequent XOR on 0011/0101 gives 0110.
5. in_valid held high continuously with out_ready=1 -> in_ready low during SHIFT/DONE, and exactly one accept per WIDTH+2 cycles.
6. WIDTH=8, x=8'hA5, y=8'h0F, op=XNOR -> result=8'h55 after 9 cycles. Random sweep checked against the package golden model.
